// File: rtl/mem_access_ctrl_pkg.sv
// Shared op encodings, FSM states and access-legality helpers for the load/store sequencer.
package mem_access_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone
  } state_e;

  function automatic logic access_legal(input logic is_store, input logic [2:0] op,
                                        input logic [1:0] lane);
    logic ok;
    case (op)
      OP_B:    ok = 1'b1;
      OP_H:    ok = ~lane[0];
      OP_W:    ok = (lane == 2'b00);
      OP_BU:   ok = ~is_store;
      OP_HU:   ok = ~is_store & ~lane[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_enables(input logic [2:0] op, input logic [1:0] lane);
    logic [3:0] be;
    case (op)
      OP_B, OP_BU: be = 4'b0001 << lane;
      OP_H, OP_HU: be = lane[1] ? 4'b1100 : 4'b0011;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/acknowledge data-memory port between the sequencer (master) and memory (slave).
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl_load_extender.sv
// Combinational load alignment: picks the addressed byte/half and zero- or sign-extends it.
module load_extender
  import mem_access_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_op,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_signed;

  always_comb begin
    w_byte   = i_word[{i_lane, 3'b000} +: 8];
    w_half   = i_lane[1] ? i_word[31:16] : i_word[15:0];
    // Unsigned variants carry opcode bit 2 set.
    w_signed = ~i_op[2];
    case (i_op)
      OP_B, OP_BU: o_result = {{24{w_signed & w_byte[7]}}, w_byte};
      OP_H, OP_HU: o_result = {{16{w_signed & w_half[15]}}, w_half};
      default:     o_result = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: one access per transaction over a req/ack memory port,
// with lane selection, store replication, load extension and timeout abort.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      is_store,
  input  logic [2:0]                op,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  mem_access_ctrl_if.master         mem,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               rdata,
  output logic                      addr_err,
  output logic                      bus_err
);

  localparam logic [15:0] TimeoutCount = 16'(TIMEOUT);

  state_e      r_state, w_state_next;
  logic        r_is_store;
  logic [2:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_addr_err;
  logic        r_bus_err;
  logic [15:0] r_wait;

  logic        w_legal;
  logic [15:0] w_wait_inc;
  logic        w_timeout;
  logic [31:0] w_load_data;

  assign w_legal    = access_legal(is_store, op, addr[1:0]);
  assign w_wait_inc = r_wait + 16'd1;
  assign w_timeout  = (w_wait_inc == TimeoutCount);

  load_extender u_load_extender (
    .i_word   (mem.mem_rdata),
    .i_lane   (r_addr[1:0]),
    .i_op     (r_op),
    .o_result (w_load_data)
  );

  always_comb begin
    w_state_next   = r_state;
    mem.mem_req    = 1'b0;
    mem.mem_we     = 1'b0;
    mem.mem_addr   = 32'd0;
    mem.mem_be     = 4'd0;
    mem.mem_wdata  = 32'd0;
    busy           = (r_state != StIdle);
    done           = 1'b0;
    addr_err       = 1'b0;
    bus_err        = 1'b0;
    rdata          = r_rdata;

    case (r_state)
      StIdle: begin
        if (start) w_state_next = w_legal ? StReq : StDone;
      end
      StReq: begin
        mem.mem_req  = 1'b1;
        mem.mem_we   = r_is_store;
        mem.mem_addr = {r_addr[31:2], 2'b00};
        mem.mem_be   = lane_enables(r_op, r_addr[1:0]);
        if (r_is_store) begin
          case (r_op[1:0])
            2'b00:   mem.mem_wdata = {4{r_wdata[7:0]}};
            2'b01:   mem.mem_wdata = {2{r_wdata[15:0]}};
            default: mem.mem_wdata = r_wdata;
          endcase
        end
        // Ack on the final allowed cycle still wins over the timeout.
        if (mem.mem_ack || w_timeout) w_state_next = StDone;
      end
      StDone: begin
        done         = 1'b1;
        addr_err     = r_addr_err;
        bus_err      = r_bus_err;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_is_store <= 1'b0;
      r_op       <= 3'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_addr_err <= 1'b0;
      r_bus_err  <= 1'b0;
      r_wait     <= 16'd0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_is_store <= is_store;
            r_op       <= op;
            r_addr     <= addr;
            r_wdata    <= wdata;
            r_wait     <= 16'd0;
            r_addr_err <= ~w_legal;
            r_bus_err  <= 1'b0;
            if (!w_legal) r_rdata <= 32'd0;
          end
        end
        StReq: begin
          r_wait <= w_wait_inc;
          if (mem.mem_ack) begin
            r_rdata <= r_is_store ? 32'd0 : w_load_data;
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_rdata   <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
